// File: rtl/seq_detect_param.sv
// Parametrised serial Mealy sequence detector.
// Matches a runtime-loaded PAT_W-bit pattern (MSB received first) on a
// qualified bit stream. Overlap mode is selected at load time. Outputs are a
// combinational match, its registered copy and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               load,
    input  logic [PAT_W-1:0]   pattern,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clr_cnt,
    output logic               armed,
    output logic               match,
    output logic               match_q,
    output logic [COUNT_W-1:0] match_count
);

    // fill counts accepted bits up to PAT_W-1, the point where history is full
    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state;
    logic [PAT_W-1:0]   pattern_reg;
    logic               overlap_reg;
    logic [PAT_W-2:0]   history;
    logic [FILL_W-1:0]  fill;

    logic [PAT_W-1:0]   window;
    logic               sample;

    // The candidate word is the stored history with the live bit appended;
    // taking its low PAT_W-1 bits as the next history also covers PAT_W=2.
    assign window = {history, in};
    assign sample = (state == ARMED) && in_valid && !load;
    assign match  = sample && (fill == FILL_MAX) && (window == pattern_reg);
    assign armed  = (state == ARMED);

    // Control FSM plus pattern, history and fill bookkeeping
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            pattern_reg <= '0;
            overlap_reg <= 1'b0;
            history     <= '0;
            fill        <= '0;
        end else if (load) begin
            // load wins over a same-cycle bit; that bit is dropped
            state       <= ARMED;
            pattern_reg <= pattern;
            overlap_reg <= overlap;
            history     <= '0;
            fill        <= '0;
        end else if (sample) begin
            if (match && !overlap_reg) begin
                // non-overlapping: the matched bits cannot start a new match
                history <= '0;
                fill    <= '0;
            end else begin
                history <= window[PAT_W-2:0];
                if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

    // Registered copy of the Mealy match
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            match_q <= 1'b0;
        else
            match_q <= match;
    end

    // Saturating match counter; a clear beats a same-cycle match
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            match_count <= '0;
        else if (clr_cnt)
            match_count <= '0;
        else if (match && (match_count != CNT_MAX))
            match_count <= match_count + 1'b1;
    end

endmodule
